// File: rtl/timer_bus_if.sv
// rtl/timer_bus_if.sv - register and valid/ready host front end for the timer peripheral
module timer_bus_if #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [3:0]       req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             tmr_enable,
  output logic [WIDTH-1:0] tmr_reload,
  output logic [WIDTH-1:0] tmr_compare,
  output logic             tmr_load,
  input  logic [WIDTH-1:0] tmr_count,
  input  logic             tmr_event,
  output logic             irq
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam logic [3:0] A_CTRL    = 4'h0;
  localparam logic [3:0] A_RELOAD  = 4'h1;
  localparam logic [3:0] A_COMPARE = 4'h2;
  localparam logic [3:0] A_STATUS  = 4'h3;
  localparam logic [3:0] A_COUNT   = 4'h4;
  localparam logic [3:0] A_EVT_CNT = 4'h5;
  localparam logic [3:0] A_CMD     = 4'h6;

  state_t      state;
  logic        cap_write;
  logic [3:0]  cap_addr;
  logic [31:0] cap_wdata;
  logic        irq_en;
  logic        one_shot;
  logic        evt_flag;
  logic        ovr_flag;
  logic        tmr_event_q;
  logic [7:0]  evt_cnt;
  logic        evt;
  logic        wr_any;
  logic        clr_evt;
  logic        clr_ovr;
  logic [31:0] rd_data;
  logic        unused_wdata;

  assign evt          = tmr_event & ~tmr_event_q;
  assign wr_any       = (state == S_ACCESS) && cap_write;
  // A coincident event wins over a write-1-to-clear of either status flag.
  assign clr_evt      = wr_any && (cap_addr == A_STATUS) && cap_wdata[0] && !evt;
  assign clr_ovr      = wr_any && (cap_addr == A_STATUS) && cap_wdata[1] && !evt;
  assign irq          = irq_en & evt_flag;
  assign unused_wdata = ^cap_wdata;

  always_comb begin
    rd_data = '0;
    case (cap_addr)
      A_CTRL:    rd_data[2:0]       = {one_shot, irq_en, tmr_enable};
      A_RELOAD:  rd_data[WIDTH-1:0] = tmr_reload;
      A_COMPARE: rd_data[WIDTH-1:0] = tmr_compare;
      A_STATUS:  rd_data[1:0]       = {ovr_flag, evt_flag};
      A_COUNT:   rd_data[WIDTH-1:0] = tmr_count;
      A_EVT_CNT: rd_data[7:0]       = evt_cnt;
      default:   rd_data            = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            req_ready <= 1'b0;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          rsp_rdata <= cap_write ? 32'd0 : rd_data;
          rsp_err   <= (cap_addr > A_CMD);
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_enable  <= 1'b0;
      irq_en      <= 1'b0;
      one_shot    <= 1'b0;
      tmr_reload  <= '1;
      tmr_compare <= '0;
      evt_flag    <= 1'b0;
      ovr_flag    <= 1'b0;
      evt_cnt     <= '0;
      tmr_load    <= 1'b0;
      tmr_event_q <= 1'b0;
    end else begin
      tmr_event_q <= tmr_event;
      tmr_load    <= wr_any && (cap_addr == A_CMD) && cap_wdata[0];

      // A host CTRL write overrides the one-shot auto-disable on the same edge.
      if (wr_any && (cap_addr == A_CTRL)) begin
        {one_shot, irq_en, tmr_enable} <= cap_wdata[2:0];
      end else if (evt && one_shot) begin
        tmr_enable <= 1'b0;
      end

      if (wr_any && (cap_addr == A_RELOAD))  tmr_reload  <= cap_wdata[WIDTH-1:0];
      if (wr_any && (cap_addr == A_COMPARE)) tmr_compare <= cap_wdata[WIDTH-1:0];

      if (evt)          evt_flag <= 1'b1;
      else if (clr_evt) evt_flag <= 1'b0;

      if (evt && evt_flag) ovr_flag <= 1'b1;
      else if (clr_ovr)    ovr_flag <= 1'b0;

      if (wr_any && (cap_addr == A_EVT_CNT)) begin
        evt_cnt <= {7'd0, evt};
      end else if (evt && (evt_cnt != 8'hFF)) begin
        evt_cnt <= evt_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_timer_bus_if.sv
// tb/tb_timer_bus_if.sv - randomized self-checking bench for timer_bus_if
`timescale 1ns/1ps
module tb_timer_bus_if;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [3:0]       req_addr;
  logic [31:0]      req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             tmr_enable;
  logic [WIDTH-1:0] tmr_reload;
  logic [WIDTH-1:0] tmr_compare;
  logic             tmr_load;
  logic [WIDTH-1:0] tmr_count;
  logic             tmr_event;
  logic             irq;

  int checks = 0;
  int errors = 0;

  logic [2:0]       m_ctrl;
  logic [WIDTH-1:0] m_reload;
  logic [WIDTH-1:0] m_compare;
  logic             m_evt;
  logic             m_ovr;
  int               m_cnt;

  timer_bus_if #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .tmr_enable(tmr_enable), .tmr_reload(tmr_reload), .tmr_compare(tmr_compare),
    .tmr_load(tmr_load), .tmr_count(tmr_count), .tmr_event(tmr_event), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic void mdl_reset();
    m_ctrl = 3'd0; m_reload = '1; m_compare = '0; m_evt = 1'b0; m_ovr = 1'b0; m_cnt = 0;
  endfunction

  // Register-level rules: write effect first, then event with event-wins priorities.
  function automatic void mdl_apply(input bit wr, input logic [3:0] a, input logic [31:0] d, input bit ev);
    bit old_evt;
    old_evt = m_evt;
    if (wr) begin
      case (a)
        4'h0: m_ctrl = d[2:0];
        4'h1: m_reload = d[WIDTH-1:0];
        4'h2: m_compare = d[WIDTH-1:0];
        4'h3: if (!ev) begin if (d[0]) m_evt = 1'b0; if (d[1]) m_ovr = 1'b0; end
        4'h5: m_cnt = 0;
        default: ;
      endcase
    end
    if (ev) begin
      m_evt = 1'b1;
      if (old_evt) m_ovr = 1'b1;
      m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      if (m_ctrl[2] && !(wr && a == 4'h0)) m_ctrl[0] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] mdl_read(input logic [3:0] a);
    case (a)
      4'h0: return {29'd0, m_ctrl};
      4'h1: return {{(32-WIDTH){1'b0}}, m_reload};
      4'h2: return {{(32-WIDTH){1'b0}}, m_compare};
      4'h3: return {30'd0, m_ovr, m_evt};
      4'h4: return {{(32-WIDTH){1'b0}}, tmr_count};
      4'h5: return 32'(m_cnt);
      default: return 32'd0;
    endcase
  endfunction

  // One host transaction; called #1 after a rising edge with the DUT idle.
  task automatic xact(input bit w, input logic [3:0] a, input logic [31:0] d, input int hold, input bit ev,
                      output logic [31:0] rd, output logic er, output bit stable,
                      output logic [WIDTH-1:0] cmp1, output logic ld0, output logic ld1, output logic ld2);
    int n;
    stable = 1'b1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready) stable = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0; req_wdata = 32'd0;
    ld0 = tmr_load;
    if (ev) tmr_event = 1'b1;
    @(posedge clk); #1;
    tmr_event = 1'b0;
    ld1 = tmr_load; cmp1 = tmr_compare;
    if (!rsp_valid || req_ready) stable = 1'b0;
    rd = rsp_rdata; er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_rdata !== rd || rsp_err !== er) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    ld2 = tmr_load;
    if (rsp_valid || !req_ready) stable = 1'b0;
    rsp_ready = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] rd; logic er; bit st; logic [WIDTH-1:0] c; logic l0, l1, l2;
    xact(1'b1, a, d, 0, 1'b0, rd, er, st, c, l0, l1, l2);
    mdl_apply(1'b1, a, d, 1'b0);
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [31:0] rd, output logic er);
    bit st; logic [WIDTH-1:0] c; logic l0, l1, l2;
    xact(1'b0, a, 32'd0, 0, 1'b0, rd, er, st, c, l0, l1, l2);
  endtask

  task automatic ev_pulse();
    tmr_event = 1'b1;
    @(posedge clk); #1;
    tmr_event = 1'b0;
    mdl_apply(1'b0, 4'h0, 32'd0, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0; mdl_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (tmr_load !== 1'b0 || tmr_enable !== 1'b0) begin errors++; $display("FAIL reset_outs load=%b en=%b exp=0,0", tmr_load, tmr_enable); end
    checks++; if (tmr_reload !== 16'hFFFF || tmr_compare !== 16'h0) begin errors++; $display("FAIL reset_cfg reload=%h cmp=%h exp=ffff,0000", tmr_reload, tmr_compare); end
    rd_reg(4'h1, rd, er);
    checks++; if (rd !== 32'h0000FFFF) begin errors++; $display("FAIL reset_read_reload got=%h exp=0000ffff", rd); end
    rd_reg(4'h0, rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL reset_read_ctrl got=%h err=%b exp=0,0", rd, er); end
  endtask

  task automatic test_rw_backpressure();
    logic [31:0] rd, d; logic er; bit st; logic [WIDTH-1:0] c; logic l0, l1, l2; logic [3:0] a;
    xact(1'b1, 4'h2, 32'h1234, 0, 1'b0, rd, er, st, c, l0, l1, l2);
    mdl_apply(1'b1, 4'h2, 32'h1234, 1'b0);
    checks++; if (c !== 16'h1234) begin errors++; $display("FAIL cmp_after_e1 got=%h exp=1234", c); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL write_handshake got=%b exp=1", st); end
    xact(1'b0, 4'h2, 32'd0, 3, 1'b0, rd, er, st, c, l0, l1, l2);
    checks++; if (rd !== 32'h1234) begin errors++; $display("FAIL bp_readback got=%h exp=00001234", rd); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL bp_rsp_stable got=%b exp=1", st); end
    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom_range(0, 2));
      d = $urandom;
      wr_reg(a, d);
      rd_reg(a, rd, er);
      checks++; if (rd !== mdl_read(a)) begin errors++; $display("FAIL rand_rw addr=%h got=%h exp=%h", a, rd, mdl_read(a)); end
    end
    checks++; if (tmr_reload !== m_reload || tmr_compare !== m_compare || tmr_enable !== m_ctrl[0])
      begin errors++; $display("FAIL rand_outs reload=%h cmp=%h en=%b exp=%h,%h,%b", tmr_reload, tmr_compare, tmr_enable, m_reload, m_compare, m_ctrl[0]); end
  endtask

  task automatic test_events();
    logic [31:0] rd; logic er; int k, h;
    wr_reg(4'h3, 32'h3); wr_reg(4'h5, 32'h0); wr_reg(4'h0, 32'h3);
    tmr_event = 1'b1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_edge got=%b exp=0", irq); end
    @(posedge clk); #1;
    tmr_event = 1'b0;
    mdl_apply(1'b0, 4'h0, 32'd0, 1'b1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_edge got=%b exp=1", irq); end
    @(posedge clk); #1;
    ev_pulse();
    rd_reg(4'h3, rd, er);
    checks++; if (rd !== mdl_read(4'h3)) begin errors++; $display("FAIL status_two_evt got=%h exp=%h", rd, mdl_read(4'h3)); end
    rd_reg(4'h5, rd, er);
    checks++; if (rd !== mdl_read(4'h5)) begin errors++; $display("FAIL evt_cnt_two got=%h exp=%h", rd, mdl_read(4'h5)); end
    wr_reg(4'h3, 32'h1);
    rd_reg(4'h3, rd, er);
    checks++; if (rd !== mdl_read(4'h3)) begin errors++; $display("FAIL status_w1c got=%h exp=%h", rd, mdl_read(4'h3)); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared got=%b exp=0", irq); end
    k = $urandom_range(1, 4);
    for (int i = 0; i < k; i++) begin
      h = $urandom_range(1, 5);
      tmr_event = 1'b1;
      repeat (h) begin @(posedge clk); #1; end
      tmr_event = 1'b0;
      mdl_apply(1'b0, 4'h0, 32'd0, 1'b1);
      @(posedge clk); #1;
    end
    rd_reg(4'h5, rd, er);
    checks++; if (rd !== mdl_read(4'h5)) begin errors++; $display("FAIL level_counts_once got=%h exp=%h", rd, mdl_read(4'h5)); end
  endtask

  task automatic test_collisions();
    logic [31:0] rd; logic er; bit st; logic [WIDTH-1:0] c; logic l0, l1, l2;
    wr_reg(4'h3, 32'h3);
    ev_pulse();
    xact(1'b1, 4'h3, 32'h1, 0, 1'b1, rd, er, st, c, l0, l1, l2);
    mdl_apply(1'b1, 4'h3, 32'h1, 1'b1);
    rd_reg(4'h3, rd, er);
    checks++; if (rd !== mdl_read(4'h3)) begin errors++; $display("FAIL w1c_vs_event got=%h exp=%h", rd, mdl_read(4'h3)); end
    wr_reg(4'h5, 32'h0);
    repeat (300) ev_pulse();
    rd_reg(4'h5, rd, er);
    checks++; if (rd !== mdl_read(4'h5)) begin errors++; $display("FAIL evt_cnt_saturate got=%h exp=%h", rd, mdl_read(4'h5)); end
    xact(1'b1, 4'h5, $urandom, 0, 1'b1, rd, er, st, c, l0, l1, l2);
    mdl_apply(1'b1, 4'h5, 32'd0, 1'b1);
    rd_reg(4'h5, rd, er);
    checks++; if (rd !== mdl_read(4'h5)) begin errors++; $display("FAIL cnt_clear_vs_event got=%h exp=%h", rd, mdl_read(4'h5)); end
  endtask

  task automatic test_oneshot_load();
    logic [31:0] rd; logic er; bit st; logic [WIDTH-1:0] c; logic l0, l1, l2;
    wr_reg(4'h0, 32'h5);
    tmr_event = 1'b1;
    checks++; if (tmr_enable !== 1'b1) begin errors++; $display("FAIL oneshot_en_before got=%b exp=1", tmr_enable); end
    @(posedge clk); #1;
    tmr_event = 1'b0;
    mdl_apply(1'b0, 4'h0, 32'd0, 1'b1);
    checks++; if (tmr_enable !== m_ctrl[0]) begin errors++; $display("FAIL oneshot_en_after got=%b exp=%b", tmr_enable, m_ctrl[0]); end
    @(posedge clk); #1;
    xact(1'b1, 4'h0, 32'h5, 0, 1'b1, rd, er, st, c, l0, l1, l2);
    mdl_apply(1'b1, 4'h0, 32'h5, 1'b1);
    checks++; if (tmr_enable !== m_ctrl[0]) begin errors++; $display("FAIL ctrl_vs_oneshot got=%b exp=%b", tmr_enable, m_ctrl[0]); end
    xact(1'b1, 4'h6, 32'h1, 0, 1'b0, rd, er, st, c, l0, l1, l2);
    checks++; if ({l0, l1, l2} !== 3'b010) begin errors++; $display("FAIL load_pulse got=%b exp=010", {l0, l1, l2}); end
    xact(1'b1, 4'h6, 32'hFFFF_FFFE, 0, 1'b0, rd, er, st, c, l0, l1, l2);
    checks++; if (l1 !== 1'b0) begin errors++; $display("FAIL load_bit0_clear got=%b exp=0", l1); end
    rd_reg(4'h6, rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL cmd_read got=%h err=%b exp=0,0", rd, er); end
    rd_reg(4'h9, rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL unmapped_read got=%h err=%b exp=0,1", rd, er); end
    xact(1'b1, 4'hF, $urandom, 0, 1'b0, rd, er, st, c, l0, l1, l2);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL unmapped_write err=%b exp=1", er); end
    tmr_count = WIDTH'($urandom);
    rd_reg(4'h4, rd, er);
    checks++; if (rd !== mdl_read(4'h4)) begin errors++; $display("FAIL count_read got=%h exp=%h", rd, mdl_read(4'h4)); end
    xact(1'b1, 4'h4, 32'h0, 0, 1'b0, rd, er, st, c, l0, l1, l2);
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL count_write got=%h err=%b exp=0,0", rd, er); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; bit seen;
    wr_reg(4'h0, 32'h3);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h2; req_wdata = 32'hABCD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mdl_reset();
    seen = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_req_ready got=%b exp=1", req_ready); end
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_rsp got=%b exp=0", seen); end
    checks++; if (tmr_enable !== 1'b0 || tmr_compare !== m_compare) begin errors++; $display("FAIL abort_cfg en=%b cmp=%h exp=0,%h", tmr_enable, tmr_compare, m_compare); end
    rd_reg(4'h0, rd, er);
    checks++; if (rd !== mdl_read(4'h0)) begin errors++; $display("FAIL abort_ctrl got=%h exp=%h", rd, mdl_read(4'h0)); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0; req_wdata = 32'd0;
    rsp_ready = 1'b0; tmr_count = '0; tmr_event = 1'b0;
    mdl_reset();
    test_reset();
    test_rw_backpressure();
    test_events();
    test_collisions();
    test_oneshot_load();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/timer_bus_if.md
# timer_bus_if

Register and handshake front end for the timer peripheral. It sits directly upstream of `timer`: it holds the enable, reload and compare configuration that drive the counter. It also consumes the timer's event output, turning it into sticky status flags, an event counter and an interrupt line. The host side is a simple valid/ready request/response port, so a soft CPU or UART bridge on the Tang Nano 9K can program the timer.

## Interface
- `WIDTH`, 16: timer counter / reload / compare width (1..32).
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  host request present.
- `req_ready`  out  1  block can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  4  word register address.
- `req_wdata`  in  32  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  host accepts response.
- `rsp_rdata`  out  32  read data, zero-extended; 0 on writes.
- `rsp_err`  out  1  access to an unmapped address.
- `tmr_enable`  out  1  CTRL.EN to timer.
- `tmr_reload`  out  WIDTH  RELOAD register to timer.
- `tmr_compare`  out  WIDTH  COMPARE register to timer.
- `tmr_load`  out  1  one-cycle pulse: timer reloads its counter.
- `tmr_count`  in  WIDTH  live timer count.
- `tmr_event`  in  1  timer event output (level; rising edge = one event).
- `irq`  out  1  interrupt, registered-state only.

## Operation
- Register map (word addresses):
  - 0x0 CTRL rw: bit0 EN, bit1 IRQ_EN, bit2 ONE_SHOT.
  - 0x1 RELOAD rw [WIDTH-1:0].
  - 0x2 COMPARE rw.
  - 0x3 STATUS: bit0 EVT, bit1 OVR; write-1-to-clear per bit.
  - 0x4 COUNT ro: `tmr_count` sampled at the access edge.
  - 0x5 EVT_CNT: 8-bit, saturates at 255; any write clears it.
  - 0x6 CMD wo: bit0 = 1 pulses `tmr_load`; reads return 0.
  - 0x7..0xF unmapped.
- Writes to read-only COUNT are ignored with `rsp_err`=0. Unmapped access: write ignored, read data 0, `rsp_err`=1. Write data bits above field width are ignored.
- Host FSM has three states:
  - IDLE: `req_ready`=1. On `req_valid`, capture write/addr/wdata, go to ACCESS.
  - ACCESS: perform the write or read sample, load the response, go to RESP.
  - RESP: `rsp_valid`=1, held stable until `rsp_ready`, then go to IDLE.
- Event detect: `evt = tmr_event & ~tmr_event_q`, with `tmr_event_q` a registered copy (reset 0).
- On `evt`:
  - EVT←1.
  - OVR←1 if EVT was already 1.
  - EVT_CNT increments, saturating.
  - If ONE_SHOT=1, EN←0.
- Same-edge priorities:
  - An event beats a W1C clear of EVT/OVR: the flag stays or becomes 1.
  - An event coincident with an EVT_CNT clear leaves EVT_CNT = 1.
  - A host write to CTRL beats a one-shot auto-clear: the written EN value stands.
- `irq` = IRQ_EN & EVT, decoded from registers.

## Timing
- Reset values:
  - `req_ready`=1 (IDLE), `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - CTRL=0, RELOAD=all ones, COMPARE=0, STATUS=0, EVT_CNT=0.
  - `tmr_load`=0, `irq`=0.
- Reset mid-transaction aborts it: the FSM returns to IDLE and no response is issued.
- Request accepted at edge E0. Write takes effect, or read data is sampled, at edge E1. `rsp_valid` is high from E1.
  - With `rsp_ready` held 1: response handshakes at E2 and `req_ready` is high again after E2. Minimum 3 cycles per transaction.
- `req_ready`=0 in ACCESS and RESP; requests presented then are not accepted.
- Register outputs (`tmr_enable`, `tmr_reload`, `tmr_compare`) change in the cycle after E1.
- `tmr_load` is high for exactly the cycle after E1 of a CMD write with bit0=1.
- Event: `tmr_event` rises before edge T → flags, counter and `irq` update from T.
  - 1-cycle latency from the sampled rise to `irq`.
  - A level held high counts once.

## Test plan
- Reset defaults: after reset, read 0x1 → `rsp_rdata`=0x0000FFFF. Read 0x0 → 0. `req_ready`=1 and `irq`=0.
- Write/readback with backpressure:
  - write COMPARE=0x1234, then read it back with `rsp_ready` low for 3 cycles.
  - Required: `rsp_rdata`=0x1234 and `rsp_valid` stable until accepted; `tmr_compare`=0x1234 the cycle after E1.
- Events and interrupt:
  - CTRL=0x3, then two `tmr_event` rising edges.
  - Required: `irq` rises 1 cycle after the first; STATUS reads 0x3; EVT_CNT=2.
  - Then write STATUS=0x1 → reads 0x2 and `irq`=0.
- Collisions:
  - W1C of EVT on the same edge as an event → EVT stays 1.
  - 300 events → EVT_CNT=255.
  - EVT_CNT clear coincident with an event → 1.
- One-shot and load:
  - CTRL=0x5, then one event → `tmr_enable` falls the cycle after.
  - CMD write 0x1 → `tmr_load` high exactly 1 cycle.
  - Read 0x9 → `rsp_err`=1, data 0.
- Reset after E0 with `reset` high 1 cycle → no `rsp_valid`; CTRL=0; `req_ready`=1.
